temperature_alarm_observer: RTL

Observer-side endpoint of the temperature observer protocol. It subscribes and unsubscribes itself with the temperature subject over a request/ready handshake, and consumes temperature notifications over a valid/ready handshake. It drives a debounced, hysteretic alarm and tracks dropped notifications by sequence number. It sits opposite temperature_monitor_module, which is the subject that publishes the notifications.

---
 rtl/temperature_observer_pkg.sv | 33 +++
 rtl/temperature_alarm_debouncer.sv | 114 +++++++++++
 rtl/temperature_alarm_observer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/temperature_observer_pkg.sv
// Shared types and helpers for the temperature observer endpoint.
package temperature_observer_pkg;

   localparam int unsigned SEQ_WIDTH = 8;

   typedef enum logic [1:0] {
      UNSUB      = 2'd0,
      SUB_REQ    = 2'd1,
      SUBSCRIBED = 2'd2,
      UNSUB_REQ  = 2'd3
   } sub_state_t;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      PENDING = 2'd1,
      ACTIVE  = 2'd2
   } alarm_state_t;

   // Add two sequence-width values and clamp at the all-ones maximum.
   function automatic logic [SEQ_WIDTH-1:0] sat_add_seq(
      input logic [SEQ_WIDTH-1:0] a,
      input logic [SEQ_WIDTH-1:0] b
   );
      logic [SEQ_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[SEQ_WIDTH]) begin
         sat_add_seq = {SEQ_WIDTH{1'b1}};
      end else begin
         sat_add_seq = sum[SEQ_WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/temperature_alarm_debouncer.sv
// Alarm FSM: debounces over-threshold samples, clears with hysteresis,
// and emits a one-cycle pulse when the alarm is raised.
module temperature_alarm_debouncer
   import temperature_observer_pkg::*;
#(
   parameter int unsigned TEMP_WIDTH     = 32,
   parameter int unsigned HYSTERESIS     = 2,
   parameter int unsigned DEBOUNCE_COUNT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_accept,
   input  logic [TEMP_WIDTH-1:0] i_temp,
   input  logic [TEMP_WIDTH-1:0] i_thr,
   input  logic                  i_force_clear,
   output logic                  o_alarm,
   output logic                  o_alarm_pulse
);

   localparam int unsigned           CNT_W   = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DEBOUNCE_COUNT);
   localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
   localparam logic [TEMP_WIDTH-1:0] HYST    = TEMP_WIDTH'(HYSTERESIS);

   alarm_state_t          r_state;
   alarm_state_t          w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [TEMP_WIDTH-1:0] w_clear_level;
   logic                  w_over;
   logic                  w_clear;
   logic                  r_alarm;
   logic                  r_pulse;

   // Over/clear decisions; the clear level floors at zero for small thresholds.
   always_comb begin
      w_clear_level = {TEMP_WIDTH{1'b0}};
      if (i_thr > HYST) begin
         w_clear_level = i_thr - HYST;
      end else begin
         w_clear_level = {TEMP_WIDTH{1'b0}};
      end
      w_over    = (i_temp > i_thr);
      w_clear   = (i_temp < w_clear_level);
      w_cnt_inc = r_cnt + CNT_ONE;
   end

   // Next-state logic; leaving the subscription overrides any sample.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (i_force_clear) begin
         w_state_nxt = NORMAL;
         w_cnt_nxt   = {CNT_W{1'b0}};
      end else if (i_accept) begin
         case (r_state)
            NORMAL: begin
               if (w_over) begin
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = (CNT_MAX == CNT_ONE) ? ACTIVE : PENDING;
               end else begin
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_state_nxt = NORMAL;
               end
            end
            PENDING: begin
               if (w_over) begin
                  w_cnt_nxt   = w_cnt_inc;
                  w_state_nxt = (w_cnt_inc == CNT_MAX) ? ACTIVE : PENDING;
               end else begin
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_state_nxt = NORMAL;
               end
            end
            ACTIVE: begin
               if (w_clear) begin
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_state_nxt = NORMAL;
               end else begin
                  w_cnt_nxt   = r_cnt;
                  w_state_nxt = ACTIVE;
               end
            end
            default: begin
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_state_nxt = NORMAL;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
      end
   end

   // State, counter and registered alarm outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= NORMAL;
         r_cnt   <= {CNT_W{1'b0}};
         r_alarm <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_alarm <= (w_state_nxt == ACTIVE);
         r_pulse <= (w_state_nxt == ACTIVE) && (r_state != ACTIVE);
      end
   end

   assign o_alarm       = r_alarm;
   assign o_alarm_pulse = r_pulse;

endmodule

// File: rtl/temperature_alarm_observer.sv
// Observer endpoint: subscription handshake, notification intake,
// threshold register and dropped-sequence tracking around the alarm FSM.
module temperature_alarm_observer
   import temperature_observer_pkg::*;
#(
   parameter int unsigned TEMP_WIDTH        = 32,
   parameter logic [31:0] OBSERVER_ID       = 32'h0000_A1A2,
   parameter int unsigned DEFAULT_THRESHOLD = 25,
   parameter int unsigned HYSTERESIS        = 2,
   parameter int unsigned DEBOUNCE_COUNT    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   output logic                  sub_req_valid,
   output logic                  sub_req_attach,
   output logic [31:0]           sub_req_id,
   input  logic                  sub_req_ready,
   input  logic                  notify_valid,
   output logic                  notify_ready,
   input  logic [TEMP_WIDTH-1:0] notify_temp,
   input  logic [SEQ_WIDTH-1:0]  notify_seq,
   input  logic                  threshold_we,
   input  logic [TEMP_WIDTH-1:0] threshold_in,
   output logic                  subscribed,
   output logic                  alarm,
   output logic                  alarm_pulse,
   output logic [TEMP_WIDTH-1:0] last_temp,
   output logic [SEQ_WIDTH-1:0]  missed_count
);

   sub_state_t            r_sub_state;
   sub_state_t            w_sub_nxt;
   logic                  r_sub_valid;
   logic                  r_sub_attach;
   logic                  r_subscribed;
   logic                  r_notify_ready;
   logic                  w_handshake;
   logic                  w_accept;
   logic                  w_force_clear;
   logic                  w_enter_sub;
   logic [TEMP_WIDTH-1:0] r_thr;
   logic [TEMP_WIDTH-1:0] w_thr_eff;
   logic [TEMP_WIDTH-1:0] r_last_temp;
   logic [SEQ_WIDTH-1:0]  r_seq_exp;
   logic                  r_seq_armed;
   logic [SEQ_WIDTH-1:0]  r_missed;
   logic [SEQ_WIDTH-1:0]  w_seq_gap;

   assign w_handshake   = r_sub_valid && sub_req_ready;
   assign w_accept      = notify_valid && r_notify_ready;
   assign w_force_clear = (w_sub_nxt == UNSUB) && (r_sub_state != UNSUB);
   assign w_enter_sub   = (w_sub_nxt == SUBSCRIBED) && (r_sub_state != SUBSCRIBED);
   assign w_thr_eff     = threshold_we ? threshold_in : r_thr;
   assign w_seq_gap     = notify_seq - r_seq_exp;

   // Subscription next state; a pending request always finishes its handshake.
   always_comb begin
      w_sub_nxt = r_sub_state;
      case (r_sub_state)
         UNSUB:      w_sub_nxt = enable      ? SUB_REQ    : UNSUB;
         SUB_REQ:    w_sub_nxt = w_handshake ? SUBSCRIBED : SUB_REQ;
         SUBSCRIBED: w_sub_nxt = enable      ? SUBSCRIBED : UNSUB_REQ;
         UNSUB_REQ:  w_sub_nxt = w_handshake ? UNSUB      : UNSUB_REQ;
         default:    w_sub_nxt = UNSUB;
      endcase
   end

   // Subscription state and its registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sub_state    <= UNSUB;
         r_sub_valid    <= 1'b0;
         r_sub_attach   <= 1'b0;
         r_subscribed   <= 1'b0;
         r_notify_ready <= 1'b0;
      end else begin
         r_sub_state    <= w_sub_nxt;
         r_sub_valid    <= (w_sub_nxt == SUB_REQ) || (w_sub_nxt == UNSUB_REQ);
         r_sub_attach   <= (w_sub_nxt == SUB_REQ);
         r_subscribed   <= (w_sub_nxt == SUBSCRIBED);
         r_notify_ready <= (w_sub_nxt == SUBSCRIBED) || (w_sub_nxt == UNSUB_REQ);
      end
   end

   // Threshold register and last accepted temperature.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_thr       <= TEMP_WIDTH'(DEFAULT_THRESHOLD);
         r_last_temp <= {TEMP_WIDTH{1'b0}};
      end else begin
         if (threshold_we) begin
            r_thr <= threshold_in;
         end
         if (w_accept) begin
            r_last_temp <= notify_temp;
         end
      end
   end

   // Sequence tracking; the first sample of each subscription only arms it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seq_exp   <= {SEQ_WIDTH{1'b0}};
         r_seq_armed <= 1'b0;
         r_missed    <= {SEQ_WIDTH{1'b0}};
      end else if (w_accept) begin
         if (r_seq_armed) begin
            r_missed <= sat_add_seq(r_missed, w_seq_gap);
         end
         r_seq_exp   <= notify_seq + SEQ_WIDTH'(1);
         r_seq_armed <= 1'b1;
      end else if (w_enter_sub) begin
         r_seq_armed <= 1'b0;
      end
   end

   temperature_alarm_debouncer #(
      .TEMP_WIDTH     (TEMP_WIDTH),
      .HYSTERESIS     (HYSTERESIS),
      .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
   ) u_debouncer (
      .clk           (clk),
      .rst           (rst),
      .i_accept      (w_accept),
      .i_temp        (notify_temp),
      .i_thr         (w_thr_eff),
      .i_force_clear (w_force_clear),
      .o_alarm       (alarm),
      .o_alarm_pulse (alarm_pulse)
   );

   assign sub_req_valid  = r_sub_valid;
   assign sub_req_attach = r_sub_attach;
   assign sub_req_id     = OBSERVER_ID;
   assign notify_ready   = r_notify_ready;
   assign subscribed     = r_subscribed;
   assign last_temp      = r_last_temp;
   assign missed_count   = r_missed;

endmodule
